// File: rtl/ula_seq_if.sv
// Request/response bundle for the sequential RV32M multiply/divide unit.
// The requester drives the operation; the unit answers with handshake and result.
interface ula_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_zero;

    modport master (output start, op, a, b, flush,
                    input  ready, busy, done, result, div_zero);
    modport slave  (input  start, op, a, b, flush,
                    output ready, busy, done, result, div_zero);
endinterface

// File: rtl/ula_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// clock on operand magnitudes, followed by a sign-fix cycle.
module ula_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ula_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             div_zero_q, div_zero_d;

    logic             accept;
    logic             is_div_in;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero_in, ovf_in, fast_in;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, fix_res;

    // Operand decode happens only at the accepting edge; nothing below reads a/b/op later.
    always_comb begin
        accept    = (state_q == IDLE || state_q == DONE) && bus.start && !bus.flush;
        is_div_in = bus.op[2];
        a_neg_in  = bus.a[WIDTH-1] &&
                    (bus.op == OP_MULH || bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM);
        b_neg_in  = bus.b[WIDTH-1] &&
                    (bus.op == OP_MULH || bus.op == OP_DIV || bus.op == OP_REM);
        a_mag     = a_neg_in ? -bus.a : bus.a;
        b_mag     = b_neg_in ? -bus.b : bus.b;
        b_zero_in = (bus.b == '0);
        ovf_in    = (bus.op == OP_DIV || bus.op == OP_REM) && (bus.a == MIN_NEG) && (bus.b == '1);
        fast_in   = is_div_in && (b_zero_in || ovf_in);
        fast_res  = bus.a;
        if (b_zero_in && !bus.op[1])
            fast_res = '1;
        else if (!b_zero_in && bus.op[1])
            fast_res = '0;
    end

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s     = neg_q ? -lo_q : lo_q;
        rem_s     = rneg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                   fix_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011:   fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:           fix_res = quo_s;
            default:                  fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)
                    state_d = fast_in ? DONE : CALC;
                else
                    state_d = IDLE;
            end
            CALC: begin
                if (bus.flush)
                    state_d = IDLE;
                else if (cnt_q == CW'(WIDTH-1))
                    state_d = FIX;
            end
            FIX:     state_d = bus.flush ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // hi/lo hold the running product (multiply) or remainder/quotient (divide).
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        m_d        = m_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    op_d  = bus.op;
                    cnt_d = '0;
                    if (fast_in) begin
                        result_d   = fast_res;
                        div_zero_d = b_zero_in;
                    end else begin
                        hi_d   = '0;
                        neg_d  = a_neg_in ^ b_neg_in;
                        rneg_d = is_div_in && a_neg_in;
                        m_d    = is_div_in ? b_mag : a_mag;
                        lo_d   = is_div_in ? a_mag : b_mag;
                    end
                end
            end
            CALC: begin
                if (!bus.flush) begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q[2]) begin
                        if (!div_diff[WIDTH]) begin
                            hi_d = div_diff[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = div_shift[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                end
            end
            FIX: begin
                if (!bus.flush) begin
                    result_d   = fix_res;
                    div_zero_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            m_q        <= m_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        bus.ready    = (state_q == IDLE) || (state_q == DONE);
        bus.busy     = (state_q == CALC) || (state_q == FIX);
        bus.done     = (state_q == DONE);
        bus.result   = result_q;
        bus.div_zero = div_zero_q;
    end

endmodule
